// File: rtl/vram_arb_pkg.sv
// ============================================================================
// Module   : vram_arb_pkg
// Purpose  : Shared types and constants for the VRAM bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        STROBE = 3'd2,
        DONE   = 3'd3,
        BLOCK  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PPU  = 2'd1,
        GNT_DMA  = 2'd2,
        GNT_CPU  = 2'd3
    } grant_t;

    localparam logic [7:0] BLOCKED_RDATA = 8'hFF;

    // Counter sized for the largest legal STROBE_CYCLES (7).
    localparam int STROBE_CYCLES_MAX = 7;
    localparam int STROBE_CNT_W      = $clog2(STROBE_CYCLES_MAX + 1);

endpackage : vram_arb_pkg

`default_nettype wire

// File: rtl/vram_arb_prio.sv
// ============================================================================
// Module   : vram_arb_prio
// Purpose  : Combinational fixed-priority picker (PPU > DMA > CPU).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_arb_prio
    import vram_arb_pkg::*;
(
    input  logic   ppu_req,
    input  logic   dma_req,
    input  logic   cpu_req,
    input  logic   ppu_active,
    input  logic   lockout_en,
    output grant_t grant,
    output logic   blocked
);

    always_comb begin
        grant   = GNT_NONE;
        blocked = 1'b0;
        if (ppu_req) begin
            grant = GNT_PPU;
        end else if (dma_req) begin
            grant = GNT_DMA;
        end else if (cpu_req) begin
            grant   = GNT_CPU;
            blocked = lockout_en & ppu_active;
        end
    end

endmodule : vram_arb_prio

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module   : vram_arbiter
// Purpose  : VRAM bus sequencer arbitrating PPU, OAM DMA and CPU accesses.
//            Optional CPU lockout during pixel transfer: VRAM_ARB_CPU_LOCKOUT_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W        = 13,
    parameter int DATA_W        = 8,
    parameter int STROBE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              ppu_active,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic              ppu_ack,
    output logic [DATA_W-1:0] ppu_rdata,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ma,
    output logic [DATA_W-1:0] md_o,
    output logic              md_oe,
    input  logic [DATA_W-1:0] md_i,
    output logic              mcs,
    output logic              moe,
    output logic              mwr,
    output logic              busy
);

`ifdef VRAM_ARB_CPU_LOCKOUT_EN
    localparam logic c_lockout_en = 1'b1;
`else
    localparam logic c_lockout_en = 1'b0;
`endif

    state_t                  r_state, w_state_nx;
    grant_t                  r_grant, w_gnt;
    logic [STROBE_CNT_W-1:0] r_cnt;
    logic                    r_we, w_we_nx;
    logic                    w_arb, w_take, w_blocked, w_last;
    logic                    w_ppu_req, w_dma_req, w_cpu_req;
    logic [ADDR_W-1:0]       w_addr_sel;

    logic [ADDR_W-1:0]       r_ma;
    logic [DATA_W-1:0]       r_md_o, r_ppu_rdata, r_dma_rdata, r_cpu_rdata;
    logic                    r_md_oe, r_mcs, r_moe, r_mwr, r_busy;
    logic                    r_ppu_ack, r_dma_ack, r_cpu_ack;

    assign w_arb  = (r_state == IDLE) || (r_state == DONE);
    assign w_last = (r_state == STROBE) && (r_cnt == '0);

    // In DONE the finishing requester still holds req; mask it so it is not re-granted.
    assign w_ppu_req = w_arb & ppu_req & ~((r_state == DONE) && (r_grant == GNT_PPU));
    assign w_dma_req = w_arb & dma_req & ~((r_state == DONE) && (r_grant == GNT_DMA));
    assign w_cpu_req = w_arb & cpu_req & ~((r_state == DONE) && (r_grant == GNT_CPU));

    vram_arb_prio u_prio (
        .ppu_req    (w_ppu_req),
        .dma_req    (w_dma_req),
        .cpu_req    (w_cpu_req),
        .ppu_active (ppu_active),
        .lockout_en (c_lockout_en),
        .grant      (w_gnt),
        .blocked    (w_blocked)
    );

    assign w_take = (w_gnt != GNT_NONE) && !w_blocked;

    always_comb begin
        w_state_nx = r_state;
        w_we_nx    = w_take ? ((w_gnt == GNT_CPU) && cpu_we) : r_we;
        w_addr_sel = cpu_addr;
        case (w_gnt)
            GNT_PPU: w_addr_sel = ppu_addr;
            GNT_DMA: w_addr_sel = dma_addr;
            default: w_addr_sel = cpu_addr;
        endcase
        case (r_state)
            IDLE, DONE: begin
                if (w_blocked)   w_state_nx = BLOCK;
                else if (w_take) w_state_nx = ADDR;
                else             w_state_nx = IDLE;
            end
            ADDR:    w_state_nx = STROBE;
            STROBE:  if (w_last) w_state_nx = DONE;
            BLOCK:   w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so every pin leaves a flop.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= IDLE;
            r_grant     <= GNT_NONE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_ma        <= '0;
            r_md_o      <= '0;
            r_md_oe     <= 1'b0;
            r_mcs       <= 1'b0;
            r_moe       <= 1'b0;
            r_mwr       <= 1'b0;
            r_busy      <= 1'b0;
            r_ppu_ack   <= 1'b0;
            r_dma_ack   <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_ppu_rdata <= '0;
            r_dma_rdata <= '0;
            r_cpu_rdata <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == ADDR)
                r_cnt <= STROBE_CNT_W'(STROBE_CYCLES - 1);
            else if ((r_state == STROBE) && (r_cnt != '0))
                r_cnt <= r_cnt - 1'b1;
            if (w_take) begin
                r_grant <= w_gnt;
                r_we    <= w_we_nx;
                r_ma    <= w_addr_sel;
                if (w_we_nx) r_md_o <= cpu_wdata;
            end
            r_mcs   <= (w_state_nx == ADDR) || (w_state_nx == STROBE);
            r_moe   <= (w_state_nx == STROBE) && !w_we_nx;
            r_mwr   <= (w_state_nx == STROBE) && w_we_nx;
            r_md_oe <= w_we_nx && ((w_state_nx == ADDR) || (w_state_nx == STROBE) ||
                                   (w_state_nx == DONE));
            r_busy  <= (w_state_nx != IDLE);
            r_ppu_ack <= w_last && (r_grant == GNT_PPU);
            r_dma_ack <= w_last && (r_grant == GNT_DMA);
            r_cpu_ack <= (w_last && (r_grant == GNT_CPU)) || w_blocked;
            if (w_last && !r_we) begin
                case (r_grant)
                    GNT_PPU: r_ppu_rdata <= md_i;
                    GNT_DMA: r_dma_rdata <= md_i;
                    GNT_CPU: r_cpu_rdata <= md_i;
                    default: ;
                endcase
            end
            if (w_blocked) r_cpu_rdata <= DATA_W'(BLOCKED_RDATA);
        end
    end

    assign ma        = r_ma;
    assign md_o      = r_md_o;
    assign md_oe     = r_md_oe;
    assign mcs       = r_mcs;
    assign moe       = r_moe;
    assign mwr       = r_mwr;
    assign busy      = r_busy;
    assign ppu_ack   = r_ppu_ack;
    assign dma_ack   = r_dma_ack;
    assign cpu_ack   = r_cpu_ack;
    assign ppu_rdata = r_ppu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign cpu_rdata = r_cpu_rdata;

endmodule : vram_arbiter

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Scoreboard bench for vram_arbiter with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

    logic        clk, nreset, ppu_active;
    logic        ppu_req, dma_req, cpu_req, cpu_we;
    logic [12:0] ppu_addr, dma_addr, cpu_addr, ma;
    logic [7:0]  cpu_wdata, ppu_rdata, dma_rdata, cpu_rdata, md_o, md_i;
    logic        ppu_ack, dma_ack, cpu_ack, md_oe, mcs, moe, mwr, busy;

    vram_arbiter dut (
        .clk(clk), .nreset(nreset), .ppu_active(ppu_active),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ma(ma), .md_o(md_o), .md_oe(md_oe), .md_i(md_i),
        .mcs(mcs), .moe(moe), .mwr(mwr), .busy(busy)
    );

    typedef struct {
        int         id;
        logic [7:0] rd;
        int         cyc;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] vram    [0:8191];
    logic [7:0] ref_mem [0:8191];
    logic [7:0] exp_cpu_rd;
    int         cyc, n_checks, n_pass;
    bit         lock_build;

    initial begin clk = 1'b0; forever #5 clk = ~clk; end
    always @(posedge clk) cyc <= cyc + 1;

    // VRAM device model
    assign md_i = moe ? vram[ma] : 8'hEE;
    always @(posedge clk) if (nreset && mwr) vram[ma] <= md_o;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    task automatic mon_ack(input int id, input logic [7:0] rd);
        exp_t e;
        if (sbq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_ack: id %0d got ack=1 expected no ack (cycle %0d)", id, cyc);
        end else begin
            e = sbq.pop_front();
            chk("ack_id", id, e.id);
            chk("ack_rdata", {24'd0, rd}, {24'd0, e.rd});
            chk("ack_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every ack and checks bus protocol.
    initial forever begin
        @(negedge clk);
        if (nreset) begin
            if (ppu_ack) mon_ack(0, ppu_rdata);
            if (dma_ack) mon_ack(1, dma_rdata);
            if (cpu_ack) mon_ack(2, cpu_rdata);
            if (moe || mwr) chk("strobe_needs_mcs", {31'd0, mcs}, 32'd1);
            if (mwr) chk("mwr_needs_md_oe_no_moe", {30'd0, md_oe, moe}, 32'd2);
        end
    end

    // Requesters release req on the edge following their ack.
    initial forever begin
        @(negedge clk);
        if (nreset && ppu_ack) begin @(posedge clk); #1; ppu_req = 1'b0; end
    end
    initial forever begin
        @(negedge clk);
        if (nreset && dma_ack) begin @(posedge clk); #1; dma_req = 1'b0; end
    end
    initial forever begin
        @(negedge clk);
        if (nreset && cpu_ack) begin @(posedge clk); #1; cpu_req = 1'b0; end
    end

    // Raises the chosen requests and predicts the acks: accesses serialize in
    // priority order, each taking 4 cycles; a locked-out CPU acks one cycle on.
    task automatic issue(input logic [2:0] m, input logic [12:0] pa, input logic [12:0] da,
                         input logic [12:0] ca, input logic we, input logic [7:0] wd,
                         input logic act, input bit predict);
        int t;
        t = cyc;
        ppu_active = act;
        ppu_addr = pa; dma_addr = da; cpu_addr = ca; cpu_we = we; cpu_wdata = wd;
        ppu_req = m[0]; dma_req = m[1]; cpu_req = m[2];
        if (predict) begin
            if (m[0]) begin sbq.push_back('{0, ref_mem[pa], t + 4}); t += 4; end
            if (m[1]) begin sbq.push_back('{1, ref_mem[da], t + 4}); t += 4; end
            if (m[2]) begin
                if (lock_build && act) begin
                    exp_cpu_rd = 8'hFF;
                    sbq.push_back('{2, exp_cpu_rd, t + 1});
                end else begin
                    if (we) ref_mem[ca] = wd;
                    else    exp_cpu_rd = ref_mem[ca];
                    sbq.push_back('{2, exp_cpu_rd, t + 4});
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sbq.size() != 0 || busy || ppu_req || dma_req || cpu_req) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            $display("FAIL timeout: got %0d pending expected 0", sbq.size());
            sbq.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic [2:0] m;
`ifdef VRAM_ARB_CPU_LOCKOUT_EN
        lock_build = 1'b1;
`else
        lock_build = 1'b0;
`endif
        cyc = 0; n_checks = 0; n_pass = 0; exp_cpu_rd = 8'h00;
        for (int i = 0; i < 8192; i++) begin
            v = 8'($urandom);
            vram[i] = v; ref_mem[i] = v;
        end
        vram[13'h0200] = 8'h3C; ref_mem[13'h0200] = 8'h3C;

        // Reset with every request high.
        nreset = 1'b0;
        ppu_active = 1'b0; cpu_we = 1'b0; cpu_wdata = 8'h00;
        ppu_addr = 13'h0100; dma_addr = 13'h0101; cpu_addr = 13'h0102;
        ppu_req = 1'b1; dma_req = 1'b1; cpu_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {27'd0, mcs, moe, mwr, md_oe, busy}, 32'd0);
        chk("rst_acks", {29'd0, ppu_ack, dma_ack, cpu_ack}, 32'd0);
        chk("rst_ma_md_o", {11'd0, ma, md_o}, 32'd0);
        chk("rst_rdata", {8'd0, ppu_rdata, dma_rdata, cpu_rdata}, 32'd0);
        @(posedge clk); #1;
        issue(3'b111, 13'h0100, 13'h0101, 13'h0102, 1'b0, 8'h00, 1'b0, 1'b1);
        nreset = 1'b1;
        wait_idle();

        // CPU write waveform.
        issue(3'b100, 13'h0, 13'h0, 13'h1234, 1'b1, 8'hA5, 1'b0, 1'b1);
        for (int t = 0; t <= 5; t++) begin
            @(negedge clk);
            chk("wr_mcs", {31'd0, mcs}, {31'd0, (t >= 1 && t <= 3)});
            chk("wr_mwr", {31'd0, mwr}, {31'd0, (t >= 2 && t <= 3)});
            chk("wr_md_oe", {31'd0, md_oe}, {31'd0, (t >= 1 && t <= 4)});
            chk("wr_moe", {31'd0, moe}, 32'd0);
            if (t >= 1 && t <= 4) chk("wr_ma_md_o", {11'd0, ma, md_o}, {11'd0, 13'h1234, 8'hA5});
        end
        wait_idle();

        // Three simultaneous requesters, contiguous.
        issue(3'b111, 13'h0030, 13'h1234, 13'h0031, 1'b0, 8'h00, 1'b0, 1'b1);
        wait_idle();

        // CPU read while the PPU is in pixel transfer.
        issue(3'b100, 13'h0, 13'h0, 13'h0010, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int t = 0; t <= 4; t++) begin
            @(negedge clk);
            chk("lock_mcs", {31'd0, mcs}, {31'd0, !lock_build && t >= 1 && t <= 3});
        end
        wait_idle();
        ppu_active = 1'b0;

        // DMA read returning 8'h3C.
        issue(3'b010, 13'h0, 13'h0200, 13'h0, 1'b0, 8'h00, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        chk("dma_rdata_3c", {23'd0, dma_ack, dma_rdata}, {23'd0, 1'b1, 8'h3C});
        wait_idle();

        // Reset during the strobe of a CPU write: no ack may follow.
        issue(3'b100, 13'h0, 13'h0, 13'h1FF0, 1'b1, 8'h5A, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2; nreset = 1'b0; #1;
        chk("abort_strobes", {28'd0, mwr, mcs, md_oe, busy}, 32'd0);
        cpu_req = 1'b0;
        repeat (2) begin @(negedge clk); chk("abort_no_ack", {31'd0, cpu_ack}, 32'd0); end
        @(posedge clk); #1; nreset = 1'b1;
        repeat (3) begin @(negedge clk); chk("abort_no_ack_after", {31'd0, cpu_ack}, 32'd0); end
        wait_idle();

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            m = 3'($urandom_range(1, 7));
            issue(m, 13'($urandom_range(0, 63)), 13'($urandom_range(0, 63)),
                  13'($urandom_range(0, 63)), 1'($urandom), 8'($urandom),
                  1'($urandom), 1'b1);
            wait_idle();
        end

        chk("sb_empty", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_vram_arbiter

`default_nettype wire

// File: doc/vram_arbiter.md
# vram_arbiter

Sequencing controller for the VRAM bus: arbitrates between the PPU fetcher, OAM DMA (VRAM-to-OAM) and the CPU. Runs one registered bus cycle at a time, drives address, chip-select, output-enable and write strobes plus the write-data enable toward the VRAM pad interface, and returns read data and a one-cycle acknowledge to the winning requester. Sits between the requesters and the VRAM pad/driver logic.

## Interface
- ADDR_W, 13, VRAM address width.
- DATA_W, 8, data width.
- STROBE_CYCLES, 2, cycles moe/mwr held active per access; legal range 1..7.

- clk  in  1  system clock; all state changes on its rising edge.
- nreset  in  1  asynchronous, active-low reset.
- ppu_active  in  1  PPU in pixel-transfer (mode 3).
- ppu_req / ppu_addr  in  1 / ADDR_W  PPU fetch request and address.
- ppu_ack / ppu_rdata  out  1 / DATA_W  PPU completion pulse and read data.
- dma_req / dma_addr  in  1 / ADDR_W  DMA read request and address.
- dma_ack / dma_rdata  out  1 / DATA_W  DMA completion pulse and read data.
- cpu_req / cpu_we / cpu_addr / cpu_wdata  in  1 / 1 / ADDR_W / DATA_W  CPU request.
- cpu_ack / cpu_rdata  out  1 / DATA_W  CPU completion pulse and read data.
- ma  out  ADDR_W  VRAM address (active-high).
- md_o / md_oe  out  DATA_W / 1  write data and its drive enable.
- md_i  in  DATA_W  VRAM read data.
- mcs / moe / mwr  out  1 each  active-high chip-select, output-enable, write strobe.
- busy  out  1  high in any state other than IDLE.

## Operation
- Priority is fixed: PPU > DMA > CPU. The CPU can starve by design. PPU and DMA accesses are always reads.
- FSM states: IDLE, ADDR, STROBE, DONE, BLOCK.
- IDLE: arbitrate. A winner moves the FSM to ADDR and latches the grant, address, we and wdata. With no request, the FSM stays in IDLE.
- ADDR (1 cycle): ma is valid and mcs=1. For a write, md_oe=1 and md_o=wdata.
- STROBE (STROBE_CYCLES cycles, down-counter): mcs=1. moe=1 for a read, or mwr=1 for a write. On the clock edge ending the last STROBE cycle, md_i is latched into the winner's rdata register.
- DONE (1 cycle): mcs, moe and mwr are 0. ma, md_o and md_oe are held. The winner's ack is 1. Arbitration runs again here: a pending request goes straight to ADDR with no IDLE bubble, otherwise the FSM returns to IDLE.
- BLOCK: described under Configuration. One cycle with cpu_ack=1, then back to IDLE.
- Requesters hold req, addr and data stable until ack. If req drops mid-access, the access still completes and ack still pulses.
- ppu_active rising during a CPU access does not abort it. The access completes.
- Reset values: all ack outputs 0, rdata registers 0, ma 0, md_o 0, and md_oe, mcs, moe, mwr, busy all 0. The FSM is in IDLE.
- nreset asserted mid-access clears all strobes asynchronously. The aborted access never acks.

## Timing
- All outputs are registered, so strobes are glitch-free.
- Access length is STROBE_CYCLES+2 cycles; 4 at the default.
- Req sampled at edge N puts ADDR in cycle N+1. ack is in cycle N+2+STROBE_CYCLES, with rdata valid in that same cycle.
- rdata holds until that requester's next completed read.
- Back-to-back throughput: one access per STROBE_CYCLES+2 cycles.
- md_oe is asserted from ADDR through DONE, so write data stays stable on both sides of mwr.
- A blocked CPU access acks in cycle N+1.

## Configuration
- VRAM_ARB_CPU_LOCKOUT_EN defined:
  - A CPU win while ppu_active=1 goes to BLOCK instead of ADDR. No bus cycle is run.
  - cpu_ack=1 and cpu_rdata=8'hFF in that cycle. Writes are dropped.
- Not defined: the CPU arbitrates normally at lowest priority regardless of ppu_active. BLOCK is unreachable.

## Structure
- Package vram_arb_pkg contains:
  - state_t enum for {IDLE, ADDR, STROBE, DONE, BLOCK}.
  - grant_t enum for {GNT_NONE, GNT_PPU, GNT_DMA, GNT_CPU}.
  - Constant BLOCKED_RDATA = 8'hFF.
  - STROBE counter width as a localparam derived from STROBE_CYCLES.
- Sub-module vram_arb_prio: combinational fixed-priority picker. Inputs are the three reqs, ppu_active and the lockout enable; output is grant_t plus a blocked flag. The FSM, datapath latches and strobe registers stay in vram_arbiter.

## Test plan
- Reset: hold nreset=0 with all reqs high. Required: every output at its reset value and busy=0. Release nreset. Required: PPU granted first.
- CPU write, addr 13'h1234, data 8'hA5, idle bus. Required:
  - ADDR in cycle 1, mwr=1 in cycles 2–3.
  - md_oe=1 in cycles 1–4, md_o=8'hA5, cpu_ack=1 in cycle 4.
  - moe never asserted.
- ppu_req, dma_req and cpu_req raised in the same cycle. Required:
  - Grant order PPU, DMA, CPU.
  - Accesses contiguous with no IDLE cycle: acks at cycles 4, 8, 12.
- Lockout build, ppu_active=1, CPU read of 13'h0010. Required:
  - cpu_ack=1 at cycle 1 with cpu_rdata=8'hFF.
  - mcs stays 0.
  - Same stimulus without the macro: normal 4-cycle read that returns md_i.
- DMA read with md_i=8'h3C driven during STROBE. Required: dma_rdata=8'h3C with dma_ack=1 in cycle 4.
- Assert nreset=0 in STROBE of a CPU write. Required: mwr, mcs and md_oe drop immediately and no cpu_ack pulses.
